// File: rtl/sync_ram_dp.sv
// rtl/sync_ram_dp.sv - dual-port sync RAM (1W/1R) with registered read and post-reset clear sweep.
// Optional macro SYNC_RAM_UNINIT_EN adds per-word written tracking and the uninit output.
module sync_ram_dp #(
  parameter int               DWIDTH      = 8,
  parameter int               AWIDTH      = 8,
  parameter int               DEPTH       = 1 << AWIDTH,
  parameter logic [DWIDTH-1:0] FILL       = '0,
  parameter bit               WRITE_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              _mr,
  input  logic              _we,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] wd,
  input  logic              _re,
  input  logic [AWIDTH-1:0] ra,
  output logic [DWIDTH-1:0] rd,
  output logic              rd_valid,
  output logic              busy,
`ifdef SYNC_RAM_UNINIT_EN
  output logic              uninit,
`endif
  output logic              oob
);

  localparam int                IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH + 1)'(DEPTH);
  localparam logic [IW-1:0]     LAST    = IW'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state_q;
  logic [IW-1:0]       cnt_q;
  logic [DWIDTH-1:0]   rd_q, rd_d;
  logic                rd_valid_q, rd_valid_d;
  logic                oob_q;
  logic [DWIDTH-1:0]   mem_q [DEPTH];

  logic                wa_in, ra_in;
  logic                wr_req, rd_req;
  logic                wr_ok, rd_ok;
  logic                collide;
  logic [IW-1:0]       wa_idx, ra_idx;

  assign wa_in   = ({1'b0, wa} < DEPTH_W);
  assign ra_in   = ({1'b0, ra} < DEPTH_W);
  assign wr_req  = (state_q == READY) && !_we;
  assign rd_req  = (state_q == READY) && !_re;
  assign wr_ok   = wr_req && wa_in;
  assign rd_ok   = rd_req && ra_in;
  assign wa_idx  = wa[IW-1:0];
  assign ra_idx  = ra[IW-1:0];
  assign collide = wr_ok && rd_ok && (wa == ra);

`ifdef SYNC_RAM_UNINIT_EN
  localparam logic [DWIDTH-1:0] UNINIT_VAL = DWIDTH'(99);
  logic written_q [DEPTH];
  logic uninit_q, uninit_d;
  assign uninit = uninit_q;
`endif

  always_comb begin
    rd_d       = rd_q;
    rd_valid_d = 1'b0;
`ifdef SYNC_RAM_UNINIT_EN
    uninit_d   = 1'b0;
`endif
    if (rd_req) begin
      rd_valid_d = 1'b1;
      if (!ra_in) begin
        rd_d = '0;
      end else if (collide && WRITE_FIRST) begin
        rd_d = wd;
      end else begin
        rd_d = mem_q[ra_idx];
`ifdef SYNC_RAM_UNINIT_EN
        if (!written_q[ra_idx]) begin
          rd_d     = UNINIT_VAL;
          uninit_d = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!_mr) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      oob_q      <= 1'b0;
`ifdef SYNC_RAM_UNINIT_EN
      uninit_q   <= 1'b0;
`endif
    end else begin
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
`ifdef SYNC_RAM_UNINIT_EN
      uninit_q   <= uninit_d;
`endif
      if ((wr_req && !wa_in) || (rd_req && !ra_in)) begin
        oob_q <= 1'b1;
      end
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= READY;
          end
        end
        default: state_q <= READY;
      endcase
    end
  end

  // Storage has no reset: the sweep is the only thing that initialises it.
  always_ff @(posedge clk) begin
    if (_mr) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q] <= FILL;
`ifdef SYNC_RAM_UNINIT_EN
        written_q[cnt_q] <= 1'b0;
`endif
      end else if (wr_ok) begin
        mem_q[wa_idx] <= wd;
`ifdef SYNC_RAM_UNINIT_EN
        written_q[wa_idx] <= 1'b1;
`endif
      end
    end
  end

  assign rd       = rd_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == CLEAR);
  assign oob      = oob_q;

endmodule

// File: tb/tb_sync_ram_dp.sv
// tb/tb_sync_ram_dp.sv - directed bench for sync_ram_dp: clear timing, lockout, collisions, oob, mid-clear reset.
module tb_sync_ram_dp;

`ifdef SYNC_RAM_UNINIT_EN
  localparam logic [7:0] FILL_RD = 8'd99;
`else
  localparam logic [7:0] FILL_RD = 8'hA5;
`endif

  logic       clk = 1'b0;
  logic       mr_ab, mr_c;
  logic       we_n, re_n;
  logic [3:0] wa, ra;
  logic [7:0] wd;

  logic [7:0] rd_a, rd_b, rd_c;
  logic       rv_a, rv_b, rv_c;
  logic       busy_a, busy_b, busy_c;
  logic       oob_a, oob_b, oob_c;
`ifdef SYNC_RAM_UNINIT_EN
  logic       un_a, un_b, un_c;
`endif

  int nvec = 0;
  int nfail = 0;
  int n;

  always #5 clk = ~clk;

  sync_ram_dp #(.DWIDTH(8), .AWIDTH(4), .DEPTH(16), .FILL(8'hA5), .WRITE_FIRST(1'b1)) dut_a (
    .clk(clk), ._mr(mr_ab), ._we(we_n), .wa(wa), .wd(wd), ._re(re_n), .ra(ra),
    .rd(rd_a), .rd_valid(rv_a), .busy(busy_a),
`ifdef SYNC_RAM_UNINIT_EN
    .uninit(un_a),
`endif
    .oob(oob_a));

  sync_ram_dp #(.DWIDTH(8), .AWIDTH(4), .DEPTH(16), .FILL(8'hA5), .WRITE_FIRST(1'b0)) dut_b (
    .clk(clk), ._mr(mr_ab), ._we(we_n), .wa(wa), .wd(wd), ._re(re_n), .ra(ra),
    .rd(rd_b), .rd_valid(rv_b), .busy(busy_b),
`ifdef SYNC_RAM_UNINIT_EN
    .uninit(un_b),
`endif
    .oob(oob_b));

  sync_ram_dp #(.DWIDTH(8), .AWIDTH(4), .DEPTH(12), .FILL(8'hA5), .WRITE_FIRST(1'b1)) dut_c (
    .clk(clk), ._mr(mr_c), ._we(we_n), .wa(wa), .wd(wd), ._re(re_n), .ra(ra),
    .rd(rd_c), .rd_valid(rv_c), .busy(busy_c),
`ifdef SYNC_RAM_UNINIT_EN
    .uninit(un_c),
`endif
    .oob(oob_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_step(input logic [3:0] a);
    we_n = 1'b1; re_n = 1'b0; ra = a;
    tick();
  endtask

  task automatic wr_step(input logic [3:0] a, input logic [7:0] d);
    we_n = 1'b0; re_n = 1'b1; wa = a; wd = d;
    tick();
  endtask

  initial begin
    mr_ab = 1'b0; mr_c = 1'b0; we_n = 1'b1; re_n = 1'b1;
    wa = '0; ra = '0; wd = '0;
    tick();
    tick();
    check("rst_busy_a", busy_a, 1);
    check("rst_rd_a", rd_a, 0);
    check("rst_rv_a", rv_a, 0);
    check("rst_oob_a", oob_a, 0);
    check("rst_busy_c", busy_c, 1);

    // Lockout stimulus held for the whole sweep on the 16-word instances.
    we_n = 1'b0; wa = 4'd3; wd = 8'hFF; re_n = 1'b0; ra = 4'd3;
    mr_ab = 1'b1;
    n = 0;
    while (busy_a === 1'b1 && n < 40) begin
      n++;
      check("lock_rv", {rv_a, rv_b}, 0);
      check("lock_rd", rd_a, 0);
      tick();
    end
    check("clear_cycles_a", n, 16);
    check("clear_done_b", busy_b, 0);
    we_n = 1'b1; re_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      rd_step(i[3:0]);
      check("fill_rd_a", rd_a, FILL_RD);
      check("fill_rv_a", rv_a, 1);
      check("fill_rd_b", rd_b, FILL_RD);
    end

    wr_step(4'd5, 8'h3C);
    check("wr_no_rv", rv_a, 0);
    rd_step(4'd5);
    check("basic_rd", rd_a, 8'h3C);
    check("basic_rv", rv_a, 1);
    re_n = 1'b1;
    tick();
    check("idle_rv", rv_a, 0);
    check("idle_hold", rd_a, 8'h3C);

    wr_step(4'd7, 8'h22);
    we_n = 1'b0; wa = 4'd7; wd = 8'h11; re_n = 1'b0; ra = 4'd7;
    tick();
    check("coll_wf1", rd_a, 8'h11);
    check("coll_wf0", rd_b, 8'h22);
    rd_step(4'd7);
    check("coll_after_a", rd_a, 8'h11);
    check("coll_after_b", rd_b, 8'h11);

    we_n = 1'b0; wa = 4'd9; wd = 8'h5A; re_n = 1'b0; ra = 4'd5;
    tick();
    check("indep_rd", rd_a, 8'h3C);
    rd_step(4'd9);
    check("indep_wr", rd_b, 8'h5A);

    we_n = 1'b1; re_n = 1'b1;
    check("c_held_rd", rd_c, 0);
    check("c_held_oob", oob_c, 0);
    mr_c = 1'b1;
    n = 0;
    while (busy_c === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("clear_cycles_c", n, 12);

    wr_step(4'd1, 8'h77);
    check("oob_before", oob_c, 0);
    wr_step(4'd13, 8'hEE);
    check("oob_set_c", oob_c, 1);
    check("oob_clr_a", oob_a, 0);
    rd_step(4'd13);
    check("oob_rd_c", rd_c, 0);
    check("oob_rv_c", rv_c, 1);
    check("oob_sticky", oob_c, 1);
    check("a_rd13", rd_a, 8'hEE);
    rd_step(4'd1);
    check("addr1_intact", rd_c, 8'h77);
    check("oob_sticky2", oob_c, 1);
    re_n = 1'b1; mr_c = 1'b0;
    tick();
    check("rst_oob_c", oob_c, 0);
    check("rst_busy_c2", busy_c, 1);
    check("rst_rv_c", rv_c, 0);
    check("rst_rd_c", rd_c, 0);

    mr_c = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("midclear_busy", busy_c, 1);
    mr_c = 1'b0;
    tick();
    mr_c = 1'b1;
    n = 0;
    while (busy_c === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("reclear_cycles", n, 12);
    rd_step(4'd1);
    check("reclear_addr1", rd_c, FILL_RD);
    rd_step(4'd2);
    check("reclear_addr2", rd_c, FILL_RD);
`ifdef SYNC_RAM_UNINIT_EN
    check("uninit_set", un_c, 1);
`endif
    wr_step(4'd2, 8'h04);
    rd_step(4'd2);
    check("wr2_rd", rd_c, 8'h04);
    check("wr2_rv", rv_c, 1);
`ifdef SYNC_RAM_UNINIT_EN
    check("uninit_clr", un_c, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/sync_ram_dp.md
Name: sync_ram_dp

Overview:
- Parametrised clocked successor to the asynchronous 6116/62256-style RAM model.
- One write port and one independent read port, registered read data, and a hardware clear sequencer that fills memory after reset.
- Used as data RAM / stack RAM in the synchronous datapath, where the bus-contention and unassigned-marker behaviour of the async model is replaced by defined cycle behaviour.

Parameters:
- DWIDTH, 8: data width in bits.
- AWIDTH, 8: address width in bits.
- DEPTH, 1<<AWIDTH: number of words; must be <= 1<<AWIDTH.
- FILL, 0: word written to every location by the clear sequencer.
- WRITE_FIRST, 1: 1 = same-address read during write returns new data; 0 = returns old data.

Ports:
- clk  in  1  rising-edge clock for all state.
- _mr  in  1  synchronous active-low reset, sampled on rising clk.
- _we  in  1  active-low write enable, sampled on rising clk.
- wa  in  AWIDTH  write address.
- wd  in  DWIDTH  write data.
- _re  in  1  active-low read enable, sampled on rising clk.
- ra  in  AWIDTH  read address.
- rd  out  DWIDTH  registered read data.
- rd_valid  out  1  high for one cycle when rd holds data from an accepted read.
- busy  out  1  high while the clear sequencer owns the memory.
- oob  out  1  sticky; set when an accepted access addresses >= DEPTH.

Behaviour:
- Reset (_mr low at rising clk): rd=0, rd_valid=0, oob=0, busy=1, clear counter=0, state=CLEAR. Memory contents are not touched during the reset cycle itself.
- States:
  - CLEAR: each cycle writes FILL to mem[counter], then counter+1. When counter==DEPTH-1 is written, move to READY next cycle and drop busy. Total clear time is exactly DEPTH cycles after _mr rises.
  - READY: normal operation; busy=0.
- While busy=1:
  - _we and _re are ignored: no write, rd_valid stays 0, rd holds 0.
  - oob is not updated.
- Write (READY, _we low, wa<DEPTH): mem[wa]<=wd at the rising edge.
- Read (READY, _re low, ra<DEPTH): rd<=mem[ra] and rd_valid<=1 at the same edge. Latency is 1 clock from sampled _re to rd/rd_valid.
- Read not accepted in a cycle: rd_valid<=0 and rd holds its last value.
- Simultaneous write and read to the same address:
  - WRITE_FIRST=1: rd<=wd.
  - WRITE_FIRST=0: rd<=previous mem[ra].
  - Write always completes.
- Simultaneous access to different addresses: fully independent.
- Out of range (wa>=DEPTH with _we low, or ra>=DEPTH with _re low):
  - Access is dropped: no write; a read yields rd<=0, rd_valid<=1.
  - oob<=1 and stays 1 until the next _mr.
- Reset mid-clear or mid-operation: returns to CLEAR with counter=0 and the sweep restarts from address 0. In-flight reads are lost (rd_valid=0).
- No X ever driven on rd after the first reset; rd is never tristated.

Optional Feature:
- Macro SYNC_RAM_UNINIT_EN.
- When defined:
  - A per-word written bit is kept; the clear sequencer clears every bit.
  - A user write sets the bit for mem[wa].
  - A read of a word whose bit is clear returns rd=99 (truncated to DWIDTH), the unassigned marker, and pulses an extra output port uninit (1 bit, same timing as rd_valid). This replaces the FILL value for that read.
  - A same-address write-first collision counts as written.
- When not defined: no written-bit storage, no uninit port; reads return stored contents (FILL after clear).

Test Plan:
- Clear timing: DWIDTH=8, AWIDTH=4, FILL=8'hA5. Hold _mr low 2 cycles, release. Required: busy=1 for exactly 16 cycles. Read addresses 0..15 in turn; each returns 8'hA5 with rd_valid one cycle after _re.
- Basic write/read: write 8'h3C to addr 5. Next cycle read addr 5. Required: rd=8'h3C, rd_valid=1 one clock later, then rd_valid=0 with rd held at 8'h3C when _re goes high.
- Collision: same cycle _we low with wa=7, wd=8'h11 and _re low with ra=7; mem[7] previously 8'h22. Required: WRITE_FIRST=1 gives rd=8'h11; WRITE_FIRST=0 gives rd=8'h22. A following read returns 8'h11 in both cases.
- Busy lockout: during clear, drive _we low with wa=3, wd=8'hFF. Required: ignored; after clear, addr 3 reads FILL and rd_valid never pulses during busy.
- Out of range: DEPTH=12, AWIDTH=4. Write addr 13, then read addr 13. Required: oob=1 after the write edge and stays set; read gives rd=0, rd_valid=1; addr 1 unchanged. Assert _mr: oob=0.
- Reset mid-clear (with SYNC_RAM_UNINIT_EN): assert _mr at clear counter=6. Required: sweep restarts at 0 and busy lasts a full DEPTH cycles. Reading never-written addr 2 gives rd=99 and uninit=1. Write addr 2 = 8'h04, read it back: rd=8'h04, uninit=0.
